pwm_bank: RTL and testbench

//  Parametrised N-channel PWM generator with a shared period counter and programmable prescaler.
//  Per-channel duty values are double-buffered and change only at a period boundary (glitch-free).

---
 rtl/pwm_pkg.sv | 34 +++
 rtl/pwm_channel.sv | 51 +++++
 rtl/pwm_bank.sv | 83 ++++++++
 tb/tb_pwm_bank.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared register-map constants and address decode helpers for the PWM bank.
// Control registers live in the upper half of the address space (address MSB set).
package pwm_pkg;

  localparam int unsigned ADDR_FADE     = 0;
  localparam int unsigned ADDR_PRESCALE = 1;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DUTY,
    REG_FADE,
    REG_PRESCALE
  } reg_sel_e;

  // Address with its MSB stripped: the channel index or control register offset.
  function automatic int unsigned addr_index(input logic [31:0] addr, input int unsigned addr_w);
    return addr & ((32'd1 << (addr_w - 32'd1)) - 32'd1);
  endfunction

  function automatic reg_sel_e decode_reg(input logic msb, input int unsigned idx,
                                          input int unsigned channels);
    reg_sel_e sel;
    sel = REG_NONE;
    if (!msb) begin
      if (idx < channels) sel = REG_DUTY;
    end else if (idx == ADDR_FADE) begin
      sel = REG_FADE;
    end else if (idx == ADDR_PRESCALE) begin
      sel = REG_PRESCALE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (target/active), optional one-LSB-per-period
// fade toward the target, and the registered compare against the shared period counter.
module pwm_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_we,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             fade_en,
  input  logic             wrap,
  input  logic [WIDTH-1:0] cnt,
  output logic             pulse
);

  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pulse_q, pulse_d;

  // Active duty only moves at a period boundary, and it sees the target as it was
  // before any write landing on that same clk.
  always_comb begin
    target_d = tgt_we ? tgt_data : target_q;
    active_d = active_q;
    if (wrap) begin
      if (!fade_en) begin
        active_d = target_q;
      end else if (active_q < target_q) begin
        active_d = active_q + 1'b1;
      end else if (active_q > target_q) begin
        active_d = active_q - 1'b1;
      end
    end
    pulse_d = (cnt < active_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      active_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      target_q <= target_d;
      active_q <= active_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/pwm_bank.sv
// N-channel PWM bank: register decode, shared prescaler and period counter,
// and one pwm_channel per output.
module pwm_bank #(
  parameter  int CHANNELS   = 8,
  parameter  int WIDTH      = 8,
  parameter  int PRESCALE_W = 16,
  localparam int ADDR_W     = $clog2(CHANNELS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [PRESCALE_W-1:0] wr_data,
  output logic [CHANNELS-1:0]   pulse,
  output logic                  period_start
);

  import pwm_pkg::*;

  // Counter runs 0..2^WIDTH-2 so a full-scale duty of 2^WIDTH-1 stays high all period.
  localparam logic [WIDTH-1:0] CNT_MAX = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [CHANNELS-1:0]   fade_en_q, fade_en_d;
  logic [CHANNELS-1:0]   tgt_we;
  logic                  tick;
  logic                  wrap;
  int unsigned           wr_idx;
  reg_sel_e              sel;

  // The >= compare lets a prescale lowered below the running count tick right away.
  always_comb begin
    wr_idx = addr_index(32'(wr_addr), ADDR_W);
    sel    = wr_en ? decode_reg(wr_addr[ADDR_W-1], wr_idx, CHANNELS) : REG_NONE;
    for (int i = 0; i < CHANNELS; i++) begin
      tgt_we[i] = (sel == REG_DUTY) && (wr_idx == unsigned'(i));
    end
    fade_en_d  = (sel == REG_FADE) ? wr_data[CHANNELS-1:0] : fade_en_q;
    prescale_d = (sel == REG_PRESCALE) ? wr_data : prescale_q;

    tick      = (pre_cnt_q >= prescale_q);
    wrap      = tick && (cnt_q == CNT_MAX);
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    cnt_d     = cnt_q;
    if (tick) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      cnt_q      <= '0;
      fade_en_q  <= '0;
    end else begin
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      cnt_q      <= cnt_d;
      fade_en_q  <= fade_en_d;
    end
  end

  assign period_start = wrap;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tgt_we  (tgt_we[g]),
      .tgt_data(wr_data[WIDTH-1:0]),
      .fade_en (fade_en_q[g]),
      .wrap    (wrap),
      .cnt     (cnt_q),
      .pulse   (pulse[g])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Testbench for pwm_bank: directed duty/fade/prescale vectors, random register traffic,
// all checked cycle by cycle against a behavioural model of the PWM rules.
module tb_pwm_bank;

  localparam int CH     = 8;
  localparam int W      = 8;
  localparam int PW     = 16;
  localparam int MAXC   = 254;
  localparam int PERIOD = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [7:0]  pulse;
  logic        period_start;

  always #5 clk = ~clk;

  pwm_bank #(
    .CHANNELS  (CH),
    .WIDTH     (W),
    .PRESCALE_W(PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pulse       (pulse),
    .period_start(period_start)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state, plain integers
  int         m_pre, m_cnt, m_prescale, m_fade;
  int         m_tgt[CH];
  int         m_act[CH];
  logic [7:0] m_pulse;

  typedef struct {
    string       name;
    bit          pre_en;
    logic [3:0]  pre_addr;
    logic [15:0] pre_data;
    int          ch;
    bit          mid_en;
    int          mid_idx;
    logic [3:0]  mid_addr;
    logic [15:0] mid_data;
    int          nper;
    int          exp_hi[4];
  } vec_t;

  vec_t vq[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void addVec(input string name, input bit pre_en, input logic [3:0] pre_addr,
                                 input logic [15:0] pre_data, input int ch, input bit mid_en,
                                 input int mid_idx, input logic [3:0] mid_addr,
                                 input logic [15:0] mid_data, input int nper,
                                 input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.name = name; v.pre_en = pre_en; v.pre_addr = pre_addr; v.pre_data = pre_data;
    v.ch = ch; v.mid_en = mid_en; v.mid_idx = mid_idx; v.mid_addr = mid_addr;
    v.mid_data = mid_data; v.nper = nper;
    v.exp_hi[0] = e0; v.exp_hi[1] = e1; v.exp_hi[2] = e2; v.exp_hi[3] = e3;
    vq.push_back(v);
  endfunction

  task automatic modelReset();
    m_pre = 0; m_cnt = 0; m_prescale = 0; m_fade = 0; m_pulse = '0;
    for (int i = 0; i < CH; i++) begin
      m_tgt[i] = 0;
      m_act[i] = 0;
    end
  endtask

  function automatic bit modelPs();
    return (m_pre >= m_prescale) && (m_cnt == MAXC);
  endfunction

  // One clock of the PWM rules; everything uses values from before this edge.
  task automatic modelStep(input logic we, input logic [3:0] addr, input logic [15:0] data);
    bit tick, wrap;
    tick = (m_pre >= m_prescale);
    wrap = tick && (m_cnt == MAXC);
    for (int i = 0; i < CH; i++) m_pulse[i] = (m_cnt < m_act[i]);
    if (wrap) begin
      for (int i = 0; i < CH; i++) begin
        if (m_fade[i]) begin
          if (m_act[i] < m_tgt[i]) m_act[i]++;
          else if (m_act[i] > m_tgt[i]) m_act[i]--;
        end else begin
          m_act[i] = m_tgt[i];
        end
      end
    end
    if (tick) begin
      m_pre = 0;
      m_cnt = wrap ? 0 : m_cnt + 1;
    end else begin
      m_pre++;
    end
    if (we) begin
      if (!addr[3]) m_tgt[addr[2:0]] = int'(data[7:0]);
      else if (addr[2:0] == 3'd0) m_fade = int'(data[7:0]);
      else if (addr[2:0] == 3'd1) m_prescale = int'(data);
    end
  endtask

  // One full clock: drive inputs after negedge, check period_start, then check pulse after posedge.
  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [15:0] data,
                               output bit ps_o, output logic [7:0] pulse_o);
    @(negedge clk);
    wr_en = we; wr_addr = addr; wr_data = data;
    #1;
    checkOutput("period_start", int'(period_start), int'(modelPs()));
    ps_o = period_start;
    @(posedge clk);
    modelStep(we, addr, data);
    #1;
    checkOutput("pulse", int'(pulse), int'(m_pulse));
    pulse_o = pulse;
    wr_en = 1'b0;
  endtask

  task automatic waitPs(input int limit, input string name, output int n);
    bit         ps;
    logic [7:0] p;
    n = 0;
    do begin
      applyStimulus(1'b0, 4'h0, 16'h0, ps, p);
      n++;
    end while (!ps && n < limit);
    if (!ps) checkOutput({name, "_timeout"}, int'(ps), 1);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         ps;
    logic [7:0] p;
    int         n, idx, hi;
    vec_t       v;
    logic       we;
    logic [3:0] addr;
    logic [15:0] data;

    //      name        pre addr  data    ch mid idx  addr  data   n  expected high ticks
    addVec("duty64",    1, 4'h0, 16'd64,  0, 0, 0,   4'h0, 16'd0,   2, 64, 64, 0, 0);
    addVec("duty0",     1, 4'h0, 16'd0,   0, 0, 0,   4'h0, 16'd0,   1, 0, 0, 0, 0);
    addVec("duty255",   1, 4'h0, 16'd255, 0, 0, 0,   4'h0, 16'd0,   1, 255, 0, 0, 0);
    addVec("ch1_20",    1, 4'h1, 16'd20,  1, 0, 0,   4'h0, 16'd0,   1, 20, 0, 0, 0);
    addVec("glitch",    0, 4'h0, 16'd0,   1, 1, 100, 4'h1, 16'd200, 2, 20, 200, 0, 0);
    addVec("ch2_30",    1, 4'h2, 16'd30,  2, 0, 0,   4'h0, 16'd0,   1, 30, 0, 0, 0);
    addVec("wrap_wr",   0, 4'h0, 16'd0,   2, 1, 255, 4'h2, 16'd100, 3, 30, 30, 100, 0);
    addVec("ch3_10",    1, 4'h3, 16'd10,  3, 0, 0,   4'h0, 16'd0,   1, 10, 0, 0, 0);
    addVec("fade_on",   1, 4'h8, 16'h08,  3, 0, 0,   4'h0, 16'd0,   0, 0, 0, 0, 0);
    addVec("fade_up",   1, 4'h3, 16'd13,  3, 0, 0,   4'h0, 16'd0,   4, 11, 12, 13, 13);
    addVec("fade_dn",   1, 4'h3, 16'd11,  3, 0, 0,   4'h0, 16'd0,   3, 12, 11, 11, 0);
    addVec("fade_off",  1, 4'h3, 16'd50,  3, 1, 100, 4'h8, 16'h00,  2, 12, 50, 0, 0);
    addVec("bad_addr",  1, 4'hA, 16'h55,  0, 0, 0,   4'h0, 16'd0,   1, 255, 0, 0, 0);

    modelReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_pulse", int'(pulse), 0);
    checkOutput("reset_ps", int'(period_start), 0);
    rst_n = 1'b1;

    foreach (vq[k]) begin
      v = vq[k];
      if (v.pre_en) applyStimulus(1'b1, v.pre_addr, v.pre_data, ps, p);
      if (v.nper > 0) begin
        waitPs(600, v.name, n);
        idx = 0;
        for (int per = 0; per < v.nper; per++) begin
          hi = 0;
          for (int j = 0; j < PERIOD; j++) begin
            idx++;
            applyStimulus(v.mid_en && (idx == v.mid_idx), v.mid_addr, v.mid_data, ps, p);
            hi += int'(p[v.ch]);
          end
          checkOutput($sformatf("%s_p%0d", v.name, per), hi, v.exp_hi[per]);
        end
      end
    end

    // Prescale: period length, then lowering prescale below the running count
    applyStimulus(1'b1, 4'h9, 16'd3, ps, p);
    waitPs(3000, "pre3_sync", n);
    waitPs(3000, "pre3", n);
    checkOutput("prescale3_period", n, 4 * PERIOD);
    for (int g = 0; g < 3000 && !(m_cnt == MAXC && m_pre == 1); g++) begin
      applyStimulus(1'b0, 4'h0, 16'h0, ps, p);
    end
    applyStimulus(1'b1, 4'h9, 16'd1, ps, p);
    applyStimulus(1'b0, 4'h0, 16'h0, ps, p);
    checkOutput("prescale_lower_tick", int'(ps), 1);
    waitPs(3000, "pre1", n);
    checkOutput("prescale1_period", n, 2 * PERIOD);
    applyStimulus(1'b1, 4'h9, 16'd0, ps, p);

    // Random register traffic against the model
    for (int c = 0; c < 3000; c++) begin
      we   = ($urandom_range(0, 9) == 0);
      addr = 4'($urandom_range(0, 15));
      data = 16'($urandom);
      if (addr == 4'h9) data = 16'($urandom_range(0, 2));
      applyStimulus(we, addr, data, ps, p);
    end

    // Asynchronous reset with a channel held high
    applyStimulus(1'b1, 4'h9, 16'd0, ps, p);
    applyStimulus(1'b1, 4'h8, 16'h00, ps, p);
    applyStimulus(1'b1, 4'h7, 16'd255, ps, p);
    waitPs(2000, "pre_rst", n);
    repeat (5) applyStimulus(1'b0, 4'h0, 16'h0, ps, p);
    checkOutput("pre_rst_ch7_high", int'(p[7]), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pulse", int'(pulse), 0);
    checkOutput("async_rst_ps", int'(period_start), 0);
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_hold_pulse", int'(pulse), 0);
    rst_n = 1'b1;
    waitPs(600, "first_ps", n);
    checkOutput("first_ps_after_rst", n, PERIOD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
